// File: rtl/game_sequencer.sv
// game_sequencer: idle/play/pause/over flow control and move-tick generation for the 8x8 snake game.
// Optional SNAKE_SEQ_AUTO_LEVEL_EN: when defined, the speed level follows the score; otherwise level stays 0.
module game_sequencer #(
  parameter int TICK_BASE       = 6250000,
  parameter int TICK_STEP       = 625000,
  parameter int LEVEL_MAX       = 7,
  parameter int SCORE_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       key_pause,
  input  logic       game_over,
  input  logic [3:0] score,
  output logic       move_tick,
  output logic       soft_rst,
  output logic       run,
  output logic       freeze_timer,
  output logic [1:0] state,
  output logic [2:0] level
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_cnt;
  logic [23:0] w_cnt_nxt;
  logic        r_tick;
  logic        w_tick_nxt;
  logic        r_soft;
  logic        w_soft_nxt;
  logic        r_run;
  logic        r_freeze;
  logic [2:0]  r_level;
  logic [2:0]  w_level_nxt;
  logic        r_start_q;
  logic        r_pause_q;
  logic        w_start_rise;
  logic        w_pause_rise;
  logic [23:0] w_period;
  logic [23:0] w_period_m1;

  // Key history resets high so a key held through reset release gives no edge.
  assign w_start_rise = key_start & ~r_start_q;
  assign w_pause_rise = key_pause & ~r_pause_q;

`ifdef SNAKE_SEQ_AUTO_LEVEL_EN
  logic [31:0] w_quot;
  assign w_quot = {28'd0, score} / 32'(SCORE_PER_LEVEL);
  assign w_level_nxt = (w_quot > 32'(LEVEL_MAX)) ? 3'(LEVEL_MAX) : w_quot[2:0];
`else
  logic w_unused_score;
  assign w_unused_score = ^score;
  assign w_level_nxt    = 3'd0;
`endif

  // Move period shrinks by one step per level; compare against P-1.
  assign w_period    = 24'(TICK_BASE) - 24'(r_level) * 24'(TICK_STEP);
  assign w_period_m1 = w_period - 24'd1;

  // Next-state, counter and pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_soft_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_rise) begin
          w_state_nxt = S_PLAY;
          w_soft_nxt  = 1'b1;
          w_cnt_nxt   = 24'd0;
        end
      end
      S_PLAY: begin
        if (game_over) begin
          w_state_nxt = S_OVER;
        end else if (w_pause_rise) begin
          w_state_nxt = S_PAUSE;
        end else if (r_cnt >= w_period_m1) begin
          w_cnt_nxt  = 24'd0;
          w_tick_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 24'd1;
        end
      end
      S_PAUSE: begin
        if (w_pause_rise) begin
          w_state_nxt = S_PLAY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, key history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 24'd0;
      r_tick    <= 1'b0;
      r_soft    <= 1'b0;
      r_run     <= 1'b0;
      r_freeze  <= 1'b1;
      r_level   <= 3'd0;
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tick    <= w_tick_nxt;
      r_soft    <= w_soft_nxt;
      r_run     <= (w_state_nxt == S_PLAY);
      r_freeze  <= (w_state_nxt != S_PLAY);
      r_level   <= w_level_nxt;
      r_start_q <= key_start;
      r_pause_q <= key_pause;
    end
  end

  assign move_tick    = r_tick;
  assign soft_rst     = r_soft;
  assign run          = r_run;
  assign freeze_timer = r_freeze;
  assign state        = r_state;
  assign level        = r_level;

endmodule
